// File: rtl/aes256_pkg.sv
// Shared AES-256 sequencing types: FSM states, round/byte index widths and block geometry.
package aes256_pkg;
  localparam int NUM_ROUNDS  = 14;
  localparam int BLOCK_BYTES = 16;

  typedef logic [3:0] byte_idx_t;
  typedef logic [3:0] round_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_UNLOAD
  } state_t;
endpackage

// File: rtl/aes256_watchdog.sv
// Round-completion watchdog: counts consecutive stall cycles and flags the one that hits LIMIT.
module aes256_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic tick_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Fires on the LIMIT-th ticking cycle, so the caller can act on that same edge.
  assign expired_o = tick_i && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/aes256_dec_ctrl.sv
// Byte-serial AES-256 decrypt sequencer: load 16 bytes, issue rounds 14..0, unload 16 bytes.
// Optional round watchdog and sticky error_o enabled by defining AES_DEC_CTRL_TIMEOUT_EN.
module aes256_dec_ctrl #(
  parameter int NUM_ROUNDS     = aes256_pkg::NUM_ROUNDS,
  parameter int BLOCK_BYTES    = aes256_pkg::BLOCK_BYTES,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic       load_en_o,
  output logic [3:0] load_idx_o,
  output logic       round_start_o,
  output logic [3:0] round_idx_o,
  output logic       final_round_o,
  input  logic       round_done_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [3:0] out_idx_o,
  output logic       busy_o
`ifdef AES_DEC_CTRL_TIMEOUT_EN
  ,
  output logic       error_o
`endif
);
  import aes256_pkg::*;

  localparam byte_idx_t  LAST_BYTE   = byte_idx_t'(BLOCK_BYTES - 1);
  localparam round_idx_t FIRST_ROUND = round_idx_t'(NUM_ROUNDS);

  state_t     state_q, state_d;
  byte_idx_t  cnt_q, cnt_d;
  round_idx_t rnd_q, rnd_d;
  logic       accept;
  logic       wd_expired;

`ifdef AES_DEC_CTRL_TIMEOUT_EN
  logic err_q, err_d;

  // Cleared in ISSUE so every round gets a fresh budget on entering WAIT.
  aes256_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == ST_ISSUE),
    .tick_i    ((state_q == ST_WAIT) && !round_done_i),
    .expired_o (wd_expired)
  );

  assign err_d   = err_q | wd_expired;
  assign error_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`else
  logic unused_timeout;
  assign wd_expired     = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Strobes are decodes of the registered state; load_en_o follows the handshake.
  assign in_ready_o    = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign accept        = in_valid_i && in_ready_o;
  assign load_en_o     = accept;
  assign load_idx_o    = cnt_q;
  assign round_start_o = (state_q == ST_ISSUE);
  assign round_idx_o   = rnd_q;
  assign final_round_o = (rnd_q == '0);
  assign out_valid_o   = (state_q == ST_UNLOAD);
  assign out_idx_o     = cnt_q;
  assign busy_o        = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            rnd_d   = FIRST_ROUND;
            state_d = ST_ISSUE;
          end else begin
            cnt_d   = cnt_q + byte_idx_t'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (round_done_i) begin
          if (rnd_q == '0) begin
            state_d = ST_UNLOAD;
          end else begin
            rnd_d   = rnd_q - round_idx_t'(1);
            state_d = ST_ISSUE;
          end
        end else if (wd_expired) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_UNLOAD: begin
        if (out_ready_i) begin
          if (cnt_q == LAST_BYTE) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + byte_idx_t'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rnd_q   <= FIRST_ROUND;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rnd_q   <= rnd_d;
    end
  end
endmodule

// File: tb/tb_aes256_dec_ctrl.sv
// Randomized bench for aes256_dec_ctrl against an event-count model of one block's life.
module tb_aes256_dec_ctrl;
  localparam int TO = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       in_valid_i = 1'b0;
  logic       round_done_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       in_ready_o, load_en_o, round_start_o, final_round_o, out_valid_o, busy_o;
  logic [3:0] load_idx_o, round_idx_o, out_idx_o;
`ifdef AES_DEC_CTRL_TIMEOUT_EN
  logic       error_o;
`endif

  aes256_dec_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .load_en_o     (load_en_o),
    .load_idx_o    (load_idx_o),
    .round_start_o (round_start_o),
    .round_idx_o   (round_idx_o),
    .final_round_o (final_round_o),
    .round_done_i  (round_done_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_idx_o     (out_idx_o),
    .busy_o        (busy_o)
`ifdef AES_DEC_CTRL_TIMEOUT_EN
    ,
    .error_o       (error_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model: a block is 16 loads, then 15 (start, done) round pairs, then 16 unloads.
  int ld, st, dn, un, since, n_ld, n_rs, blocks;
  bit ipend;

  task automatic model_reset();
    ld = 0; st = 0; dn = 0; un = 0; since = 0; n_ld = 0; n_rs = 0; ipend = 0;
  endtask

  task automatic cyc(input bit iv, input bit rd, input bit ordy);
    @(negedge clk_i);
    in_valid_i = iv; round_done_i = rd; out_ready_i = ordy;
    #1;
    chk("in_ready", in_ready_o, ld < 16);
    chk("load_en", load_en_o, iv && ld < 16);
    if (iv && ld < 16) chk("load_idx", load_idx_o, ld);
    chk("round_start", round_start_o, ipend);
    if (ipend || st > dn) begin
      chk("round_idx", round_idx_o, 14 - dn);
      chk("final_round", final_round_o, dn == 14);
    end
    chk("out_valid", out_valid_o, dn == 15);
    if (dn == 15) chk("out_idx", out_idx_o, un);
    chk("busy", busy_o, ld > 0);
`ifdef AES_DEC_CTRL_TIMEOUT_EN
    chk("error_quiet", error_o, 0);
`endif
    if (load_en_o) n_ld++;
    if (round_start_o) n_rs++;
    since++;
    if (ld < 16) begin
      if (iv) begin
        ld++;
        if (ld == 16) ipend = 1;
      end
    end else if (ipend) begin
      st++; ipend = 0; since = 0;
    end else if (st > dn) begin
      if (rd) begin
        dn++;
        if (dn < 15) ipend = 1;
      end
    end else if (ordy) begin
      un++;
      if (un == 16) begin
        chk("load_pulses", n_ld, 16);
        chk("start_pulses", n_rs, 15);
        blocks++;
        model_reset();
      end
    end
  endtask

  // mode 0: back-to-back load, done 3 cycles after start, ready toggling
  // mode 1: valid every other cycle, random done/ready; 2: fully random
  task automatic run(input int mode, input int nblk);
    int tgt, budget;
    bit tog, iv, rd, ordy;
    tgt = blocks + nblk; budget = 4000; tog = 1;
    while (blocks < tgt && budget > 0) begin
      case (mode)
        0:       begin iv = 1; rd = (st > dn) && (since == 2); ordy = tog; end
        1:       begin iv = tog; rd = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1)); end
        default: begin iv = 1'($urandom_range(0, 1)); rd = ($urandom_range(0, 3) == 0); ordy = 1'($urandom_range(0, 1)); end
      endcase
      tog = !tog;
      cyc(iv, rd, ordy);
      budget--;
    end
    chk("block_budget", blocks >= tgt, 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    in_valid_i = 0; round_done_i = 0; out_ready_i = 0; rst_i = 1;
    #1;
    chk("rst_ready", in_ready_o, 1);
    chk("rst_round_idx", round_idx_o, 14);
    chk("rst_busy", busy_o, 0);
    chk("rst_start", round_start_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 0;
  endtask

  initial begin
    int guard;
    blocks = 0;
    model_reset();
    @(negedge clk_i);
    #1;
    chk("reset_in_ready", in_ready_o, 1);
    chk("reset_load_en", load_en_o, 0);
    chk("reset_start", round_start_o, 0);
    chk("reset_round_idx", round_idx_o, 14);
    chk("reset_final", final_round_o, 0);
    chk("reset_out_valid", out_valid_o, 0);
    chk("reset_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 0;

    run(0, 1);
    run(1, 2);
    run(2, 3);

    // Abort in WAIT at round 7, then confirm the next block is clean.
    guard = 0;
    while (!(st > dn && 14 - dn == 7) && guard < 2000) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("reach_round7", guard < 2000, 1);
    pulse_reset();
    run(2, 1);

`ifdef AES_DEC_CTRL_TIMEOUT_EN
    pulse_reset();
    repeat (16) cyc(1, 0, 0);
    for (int k = 0; k <= TO; k++) begin
      @(negedge clk_i);
      in_valid_i = 0; round_done_i = 0; out_ready_i = 0;
      #1;
      if (k == 0) chk("to_start", round_start_o, 1);
      else begin
        chk("to_busy", busy_o, 1);
        chk("to_err_low", error_o, 0);
      end
    end
    @(negedge clk_i);
    #1;
    chk("to_error", error_o, 1);
    chk("to_idle", busy_o, 0);
    chk("to_ready", in_ready_o, 1);
    repeat (5) @(negedge clk_i);
    #1;
    chk("to_sticky", error_o, 1);
    pulse_reset();
    #1;
    chk("to_cleared", error_o, 0);
    run(2, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end
endmodule

// File: doc/aes256_dec_ctrl.md
Name: aes256_dec_ctrl

Overview:
- Sequencing controller for the byte-serial AES-256 decrypt datapath.
- Accepts a 16-byte ciphertext block over a valid/ready byte stream and drives datapath load strobes.
- Issues 15 round commands in decryption order: key index 14 down to 0.
- Then presents the 16 plaintext byte indices on a valid/ready output stream. Holds no key or data storage itself.

Parameters:
- NUM_ROUNDS, 14, AES-256 round count; round_idx_o runs NUM_ROUNDS..0.
- BLOCK_BYTES, 16, bytes per block for load and unload.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with AES_DEC_CTRL_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- in_valid_i  in  1  ciphertext byte valid
- in_ready_o  out  1  controller can accept a byte
- load_en_o  out  1  datapath write strobe for the byte on data_i
- load_idx_o  out  4  byte position for load_en_o
- round_start_o  out  1  one-cycle pulse: datapath begins the round
- round_idx_o  out  4  current round-key index
- final_round_o  out  1  high when round_idx_o==0 (skip InvMixColumns)
- round_done_i  in  1  datapath finished the current round
- out_valid_o  out  1  plaintext byte at out_idx_o is valid on data_o
- out_ready_i  in  1  consumer accepts the byte
- out_idx_o  out  4  byte position being unloaded
- busy_o  out  1  high in every state except IDLE
- error_o  out  1  sticky watchdog error; present only with AES_DEC_CTRL_TIMEOUT_EN

Behaviour:
- Reset (async, rst_i=1): state IDLE, byte counter 0, round_idx 14.
- Outputs at reset: in_ready_o=1, all other outputs 0, round_idx_o=14.
- Reset asserted mid-operation aborts immediately; the partial block is discarded.
- States: IDLE, LOAD, ISSUE, WAIT, UNLOAD.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i&&in_ready_o: load_en_o=1 (combinational, same cycle), load_idx_o=0, counter<=1, go to LOAD.
- LOAD:
  - in_ready_o=1; each accepted byte sets load_en_o=1 with load_idx_o=counter, counter++.
  - Accept at counter==15 -> counter<=0, round_idx<=14, go to ISSUE.
  - No accept -> hold state.
- ISSUE:
  - in_ready_o=0, round_start_o=1 for exactly this cycle, go to WAIT.
  - round_done_i is ignored in ISSUE.
- WAIT:
  - On round_done_i: if round_idx==0, go to UNLOAD; else round_idx--, go to ISSUE.
  - Latency from round_done_i to the next round_start_o is 1 cycle.
- UNLOAD:
  - out_valid_o=1, out_idx_o=counter.
  - On out_ready_i: counter++; accept at counter==15 -> counter<=0, go to IDLE.
  - out_valid_o stays high with a stable index until accepted.
- round_done_i outside WAIT is ignored.
- in_valid_i outside IDLE/LOAD is ignored; in_ready_o=0 there.
- Counter is 4-bit and wraps 15->0 only at the block boundary.
- round_idx_o and final_round_o are valid in ISSUE and WAIT; they hold the last value elsewhere.
- Minimum block time: 16 load cycles + 15×(1+datapath latency) + 16 unload cycles.

Optional Feature:
- Macro: AES_DEC_CTRL_TIMEOUT_EN.
- Defined:
  - Watchdog counter cleared on entering WAIT, increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without round_done_i sets error_o=1 and forces IDLE.
  - error_o is cleared only by rst_i.
- Undefined: no watchdog, no error_o port; WAIT waits indefinitely.

Decomposition:
- Package aes256_pkg:
  - state_t enum
  - NUM_ROUNDS=14, BLOCK_BYTES=16
  - byte_idx_t (4-bit) and round_idx_t (4-bit) typedefs
- Shared with the datapath and the encrypt side.
- Optional sub-module aes256_watchdog (counter plus compare, instantiated under the macro). Everything else stays flat.

Test Plan:
- Reset then 16 back-to-back bytes 0x00..0x0F with in_valid_i=1 -> load_idx_o 0..15 with load_en_o each cycle; round_start_o rises on cycle 17 with round_idx_o=14.
- round_done_i returned 3 cycles after each start -> 15 round_start_o pulses, round_idx_o 14,13,..,0; final_round_o=1 only on index 0; then out_valid_o=1 with out_idx_o=0.
- out_ready_i toggling 1,0,1,0 -> out_idx_o advances only on accept cycles; IDLE and busy_o=0 after the 16th accept.
- in_valid_i gapped every other cycle during LOAD -> exactly 16 load_en_o pulses, no index skips; round_done_i pulsed during LOAD has no effect.
- rst_i asserted in WAIT at round_idx_o=7 -> immediately IDLE, in_ready_o=1, round_idx_o=14; the next block runs normally.
- With AES_DEC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, round_done_i withheld -> error_o=1 after 8 WAIT cycles, state IDLE, error_o held until rst_i.
